// File: rtl/seq_stage_ctrl.sv
// rtl/seq_stage_ctrl.sv - multi-cycle stage sequencer for the SEQ Y86-64 datapath (optional SINGLE_STEP_EN)
module seq_stage_ctrl #(
  parameter int                  PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [3:0]          icode,
  input  logic                instr_valid,
  input  logic                imem_error,
  input  logic [PC_WIDTH-1:0] valC,
  input  logic [PC_WIDTH-1:0] valP,
  input  logic                cnd,
  input  logic [PC_WIDTH-1:0] valM,
  input  logic                dmem_ready,
  input  logic                dmem_error,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                exec_en,
  output logic                mem_en,
  output logic                wb_en,
  output logic                pc_en,
  output logic [2:0]          stat,
  output logic                busy,
  output logic                halted,
  output logic [31:0]         instr_count
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Wide enough to hold MEM_TIMEOUT itself, so the limit compare never aliases.
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
`ifdef SINGLE_STEP_EN
    S_PAUSE,
`endif
    S_HALT
  } state_t;

  state_t                state_q, state_nxt;
  logic [2:0]            stat_nxt;
  logic [PC_WIDTH-1:0]   pc_nxt;
  logic [3:0]            icode_q;
  logic [PC_WIDTH-1:0]   valc_q;
  logic [PC_WIDTH-1:0]   valp_q;
  logic [PC_WIDTH-1:0]   valm_q;
  logic                  cnd_q;
  logic [WCW-1:0]        wait_cnt;
  logic                  mem_op;

  // Instructions that touch data memory and therefore may see wait states.
  always_comb begin
    mem_op = 1'b0;
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_op = 1'b1;
      default:                            mem_op = 1'b0;
    endcase
  end

  // Next-state and status selection; status only changes on a HALT transition.
  always_comb begin
    state_nxt = state_q;
    stat_nxt  = stat;
    case (state_q)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end else if (!instr_valid) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_HLT;
        end else begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (!mem_op) begin
          state_nxt = S_WRITEBACK;
        end else if (dmem_ready) begin
          if (dmem_error) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          // This is the MEM_TIMEOUT-th cycle without a response.
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPD;
`ifdef SINGLE_STEP_EN
      S_PCUPD: state_nxt = S_PAUSE;
      S_PAUSE: begin
        if (step) state_nxt = S_FETCH;
      end
`else
      S_PCUPD: state_nxt = S_FETCH;
`endif
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next-PC select from the latched instruction fields.
  always_comb begin
    pc_nxt = valp_q;
    if (icode_q == 4'h8) begin
      pc_nxt = valc_q;
    end else if (icode_q == 4'h7 && cnd_q) begin
      pc_nxt = valc_q;
    end else if (icode_q == 4'h9) begin
      pc_nxt = valm_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // Architectural state: PC, status and retired-instruction count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      stat        <= STAT_AOK;
      instr_count <= 32'd0;
    end else begin
      stat <= stat_nxt;
      if (state_q == S_PCUPD) begin
        pc          <= pc_nxt;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  // Capture upstream results at the exit of the stage that produces them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      icode_q <= 4'h0;
      valc_q  <= '0;
      valp_q  <= '0;
      valm_q  <= '0;
      cnd_q   <= 1'b0;
    end else begin
      if (state_q == S_FETCH) begin
        icode_q <= icode;
        valc_q  <= valC;
        valp_q  <= valP;
      end
      if (state_q == S_EXECUTE) cnd_q <= cnd;
      if (state_q == S_MEMORY && dmem_ready) valm_q <= valM;
    end
  end

  // Memory wait counter, cleared on the way into MEMORY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_q == S_EXECUTE) begin
      wait_cnt <= '0;
    end else if (state_q == S_MEMORY && !dmem_ready && wait_cnt != WAIT_LAST) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Moore decode of stage enables and status flags.
  assign fetch_en  = (state_q == S_FETCH);
  assign decode_en = (state_q == S_DECODE);
  assign exec_en   = (state_q == S_EXECUTE);
  assign mem_en    = (state_q == S_MEMORY);
  assign wb_en     = (state_q == S_WRITEBACK);
  assign pc_en     = (state_q == S_PCUPD);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb/tb_seq_stage_ctrl.sv - directed vector bench for seq_stage_ctrl
module tb_seq_stage_ctrl;

  localparam int PW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    icode = 4'h0;
  logic          instr_valid = 1'b0;
  logic          imem_error = 1'b0;
  logic [PW-1:0] valC = '0;
  logic [PW-1:0] valP = '0;
  logic          cnd = 1'b0;
  logic [PW-1:0] valM = '0;
  logic          dmem_ready = 1'b0;
  logic          dmem_error = 1'b0;
  logic [PW-1:0] pc;
  logic          fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
  logic [2:0]    stat;
  logic          busy, halted;
  logic [31:0]   instr_count;
`ifdef SINGLE_STEP_EN
  logic          step = 1'b1;
`endif

  seq_stage_ctrl #(.PC_WIDTH(PW), .RESET_PC('0), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .icode(icode), .instr_valid(instr_valid), .imem_error(imem_error),
    .valC(valC), .valP(valP), .cnd(cnd), .valM(valM),
    .dmem_ready(dmem_ready), .dmem_error(dmem_error),
    .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en),
    .stat(stat), .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          do_reset;
    logic [3:0]    icode;
    logic          instr_valid;
    logic          imem_error;
    logic          cnd;
    logic          dmem_err;
    logic [PW-1:0] valc;
    logic [PW-1:0] valp;
    logic [PW-1:0] valm;
    int            waits;
    int            exp_cyc;
    int            exp_mem;
    logic [PW-1:0] exp_pc;
    logic [2:0]    exp_stat;
    logic [31:0]   exp_cnt;
    logic          exp_halt;
  } vec_t;

  vec_t vecs[12];
  int   n_vec = 0;
  int   n_bad = 0;
  localparam logic [PW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rs, input logic [3:0] ic, input logic iv, input logic ie,
                              input logic c, input logic de, input logic [PW-1:0] vc,
                              input logic [PW-1:0] vp, input logic [PW-1:0] vm, input int w,
                              input int ecyc, input int emem, input logic [PW-1:0] epc,
                              input logic [2:0] est, input logic [31:0] ecnt, input logic eh);
    vec_t v;
    v.do_reset = rs; v.icode = ic; v.instr_valid = iv; v.imem_error = ie;
    v.cnd = c; v.dmem_err = de; v.valc = vc; v.valp = vp; v.valm = vm; v.waits = w;
    v.exp_cyc = ecyc; v.exp_mem = emem; v.exp_pc = epc; v.exp_stat = est;
    v.exp_cnt = ecnt; v.exp_halt = eh;
    return v;
  endfunction

  function automatic logic [5:0] enables();
    return {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en};
  endfunction

  // Reset, confirm the reset state, confirm IDLE holds, then start into FETCH.
  task automatic reset_and_start(input string tag);
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    chk({tag, " rst pc"}, pc, '0);
    chk({tag, " rst stat"}, PW'(stat), PW'(1));
    chk({tag, " rst count"}, PW'(instr_count), '0);
    chk({tag, " rst enables"}, PW'({enables(), busy, halted}), '0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk({tag, " idle holds"}, PW'({enables(), busy}), '0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " fetch after start"}, PW'(enables()), PW'(6'b100000));
  endtask

  // Run one instruction from FETCH until the next FETCH or HALT.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0;
    int memc = 0;
    int last = 0;
    int idx;
    logic shape_ok = 1'b1;
    logic done = 1'b0;
    logic rdy;
    for (int g = 0; g < 60 && !done; g++) begin
      if (halted || (fetch_en && cyc > 0)) begin
        done = 1'b1;
      end else begin
        if (!$onehot(enables())) shape_ok = 1'b0;
        idx = fetch_en ? 0 : decode_en ? 1 : exec_en ? 2 : mem_en ? 3 : wb_en ? 4 : 5;
        if (idx != last && idx != last + 1) shape_ok = 1'b0;
        last = idx;
        if (fetch_en) begin
          icode = v.icode; instr_valid = v.instr_valid; imem_error = v.imem_error;
          valC = v.valc; valP = v.valp;
        end else begin
          icode = ~v.icode; instr_valid = 1'b0; imem_error = 1'b1;
          valC = JUNK; valP = JUNK;
        end
        cnd = exec_en ? v.cnd : ~v.cnd;
        rdy = mem_en && (memc >= v.waits);
        dmem_ready = rdy;
        dmem_error = mem_en ? (rdy ? v.dmem_err : 1'b1) : 1'b0;
        valM = rdy ? v.valm : JUNK;
        cyc++;
        if (mem_en) memc++;
        tick();
      end
    end
    if (!done) chk({tag, " timeout"}, PW'(0), PW'(1));
    chk({tag, " stage shape"}, PW'(shape_ok), PW'(1));
    chk({tag, " cycles"}, PW'(cyc), PW'(v.exp_cyc));
    chk({tag, " mem cycles"}, PW'(memc), PW'(v.exp_mem));
    chk({tag, " pc"}, pc, v.exp_pc);
    chk({tag, " stat"}, PW'(stat), PW'(v.exp_stat));
    chk({tag, " count"}, PW'(instr_count), PW'(v.exp_cnt));
    chk({tag, " halted"}, PW'({halted, busy}), PW'({v.exp_halt, ~v.exp_halt}));
    dmem_ready = 1'b0;
    dmem_error = 1'b0;
  endtask

  initial begin
    //            rst  ic   iv  ie  cnd de  valC    valP     valM     w    cyc mem pc       st  cnt halt
    vecs[0]  = mk(1, 4'h1, 1, 0, 0, 0, 64'h0,   64'h1,   64'h0,   5,   6,  1, 64'h1,   1,  1, 0);
    vecs[1]  = mk(0, 4'h7, 1, 0, 1, 0, 64'h40,  64'hA,   64'h0,   5,   6,  1, 64'h40,  1,  2, 0);
    vecs[2]  = mk(0, 4'h7, 1, 0, 0, 0, 64'h40,  64'h9,   64'h0,   5,   6,  1, 64'h9,   1,  3, 0);
    vecs[3]  = mk(0, 4'h8, 1, 0, 0, 0, 64'h80,  64'h12,  64'h0,   0,   6,  1, 64'h80,  1,  4, 0);
    vecs[4]  = mk(0, 4'h9, 1, 0, 0, 0, 64'h0,   64'h82,  64'h100, 3,   9,  4, 64'h100, 1,  5, 0);
    vecs[5]  = mk(0, 4'h5, 1, 0, 0, 0, 64'h0,   64'h10A, 64'h55,  1,   7,  2, 64'h10A, 1,  6, 0);
    vecs[6]  = mk(0, 4'h6, 1, 0, 1, 0, 64'h77,  64'h10C, 64'h0,   5,   6,  1, 64'h10C, 1,  7, 0);
    vecs[7]  = mk(0, 4'h0, 1, 0, 0, 0, 64'h0,   64'h10D, 64'h0,   0,   1,  0, 64'h10C, 2,  7, 1);
    vecs[8]  = mk(1, 4'h1, 1, 1, 0, 0, 64'h0,   64'h1,   64'h0,   0,   1,  0, 64'h0,   3,  0, 1);
    vecs[9]  = mk(1, 4'h1, 0, 0, 0, 0, 64'h0,   64'h1,   64'h0,   0,   1,  0, 64'h0,   4,  0, 1);
    vecs[10] = mk(1, 4'h4, 1, 0, 0, 1, 64'h0,   64'hA,   64'h0,   2,   6,  3, 64'h0,   3,  0, 1);
    vecs[11] = mk(1, 4'h5, 1, 0, 0, 0, 64'h0,   64'hA,   64'h0,   100, 11, 8, 64'h0,   3,  0, 1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_reset) reset_and_start($sformatf("v%0d", i));
      run_vec(vecs[i], $sformatf("v%0d", i));
      if (i == 7) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("halt ignores start", PW'({enables(), busy, halted}), PW'(8'b0000_0001));
        chk("halt pc frozen", pc, 64'h10C);
        chk("halt stat frozen", PW'(stat), PW'(2));
      end
    end

    reset_and_start("midrst");
    run_vec(vecs[0], "midrst nop");
    icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0; valP = 64'h7; valC = 64'h0;
    dmem_ready = 1'b0; dmem_error = 1'b0;
    tick();
    tick();
    tick();
    chk("midrst in memory", PW'(enables()), PW'(6'b000100));
    tick();
    chk("midrst still waiting", PW'(enables()), PW'(6'b000100));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst pc", pc, '0);
    chk("midrst count", PW'(instr_count), '0);
    chk("midrst stat", PW'(stat), PW'(1));
    chk("midrst idle", PW'({enables(), busy, halted}), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
